// File: rtl/fmap_rd_resp.sv
// Feature-map read responder: queues burst requests, streams each burst from a
// 1-cycle-latency SRAM. Optional `FMAP_RD_RREADY_EN adds rready backpressure via a skid buffer.
module fmap_rd_resp #(
    parameter int AW        = 32,
    parameter int DW        = 16,
    parameter int MEM_AW    = 16,
    parameter int MAX_BLOG2 = 5,
    parameter int QDEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     araddr,
    input  logic              arvalid,
    input  logic [3:0]        arburst,
    output logic              arready,
    output logic              mem_en,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [DW-1:0]     mem_rdata,
    output logic [DW-1:0]     rdata,
    output logic              rvalid,
    output logic              rlast,
`ifdef FMAP_RD_RREADY_EN
    input  logic              rready,
`endif
    output logic              ovf_err
);

    localparam int BCW = (MAX_BLOG2 > 0) ? MAX_BLOG2 : 1;
    localparam int QPW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int QCW = $clog2(QDEPTH + 1);
    localparam logic [3:0] MAX_B = 4'(MAX_BLOG2);

    typedef enum logic {IDLE, BURST} state_t;

    state_t           state, next_state;
    logic [AW-1:0]    q_addr  [QDEPTH];
    logic [3:0]       q_blog2 [QDEPTH];
    logic [QPW-1:0]   q_wr, q_rd;
    logic [QCW-1:0]   q_cnt;
    logic             q_empty, q_full, enq, deq, clamp;
    logic [3:0]       req_blog2;
    logic [BCW-1:0]   head_beat, beat_q, cur_beat;
    logic [AW-1:0]    addr_q, cur_addr;
    logic             issue, last_beat, can_issue;
    logic             ret_valid, ret_last;

    function automatic logic [QPW-1:0] ptr_inc(input logic [QPW-1:0] p);
        return (p == QPW'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign q_empty   = (q_cnt == '0);
    assign q_full    = (q_cnt == QCW'(QDEPTH));
    assign clamp     = (arburst > MAX_B);
    assign req_blog2 = clamp ? MAX_B : arburst;
    assign arready   = !q_full || deq;
    assign enq       = arvalid && arready;
    // Beats minus one for the head entry: all-ones mask shortened by the clamp headroom.
    assign head_beat = {BCW{1'b1}} >> (MAX_B - q_blog2[q_rd]);

    // NOTE: queue storage has no reset; entries are only read once q_cnt marks them valid.
    always_ff @(posedge clk) begin
        if (enq) begin
            q_addr[q_wr]  <= araddr;
            q_blog2[q_wr] <= req_blog2;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_wr  <= '0;
            q_rd  <= '0;
            q_cnt <= '0;
        end else begin
            if (enq) q_wr <= ptr_inc(q_wr);
            if (deq) q_rd <= ptr_inc(q_rd);
            case ({enq, deq})
                2'b10:   q_cnt <= q_cnt + 1'b1;
                2'b01:   q_cnt <= q_cnt - 1'b1;
                default: q_cnt <= q_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (issue && cur_beat != '0) next_state = BURST;
            BURST:   if (issue && beat_q == '0 && q_empty) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    // IDLE issues the head's first beat directly, giving mem_en the cycle after enqueue.
    always_comb begin
        issue    = 1'b0;
        deq      = 1'b0;
        cur_addr = addr_q;
        cur_beat = beat_q;
        case (state)
            IDLE: if (!q_empty && can_issue) begin
                issue    = 1'b1;
                deq      = 1'b1;
                cur_addr = q_addr[q_rd];
                cur_beat = head_beat;
            end
            BURST: if (can_issue) begin
                issue = 1'b1;
                deq   = (beat_q == '0) && !q_empty;
            end
            default: ;
        endcase
        last_beat = issue && (cur_beat == '0);
        mem_en    = issue;
        mem_addr  = issue ? cur_addr[MEM_AW-1:0] : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q <= '0;
            beat_q <= '0;
        end else if (issue) begin
            if (state == BURST && deq) begin
                addr_q <= q_addr[q_rd];
                beat_q <= head_beat;
            end else begin
                addr_q <= cur_addr + 1'b1;
                beat_q <= cur_beat - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ret_valid <= 1'b0;
            ret_last  <= 1'b0;
            ovf_err   <= 1'b0;
        end else begin
            ret_valid <= issue;
            ret_last  <= last_beat;
            if (arvalid && (!arready || clamp)) ovf_err <= 1'b1;
        end
    end

`ifdef FMAP_RD_RREADY_EN
    logic [DW-1:0] sk_data [2];
    logic          sk_last [2];
    logic          sk_wr, sk_rd, pop;
    logic [1:0]    sk_cnt;
    logic [2:0]    occ_next;

    assign pop      = (sk_cnt != 2'd0) && rready;
    // Occupancy at the edge the next SRAM word would land; must leave it one slot.
    assign occ_next = {1'b0, sk_cnt} + {2'b00, ret_valid} - {2'b00, pop};
    assign can_issue = (occ_next <= 3'd1);

    always_ff @(posedge clk) begin
        if (ret_valid) begin
            sk_data[sk_wr] <= mem_rdata;
            sk_last[sk_wr] <= ret_last;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sk_wr  <= 1'b0;
            sk_rd  <= 1'b0;
            sk_cnt <= 2'd0;
        end else begin
            if (ret_valid) sk_wr <= ~sk_wr;
            if (pop)       sk_rd <= ~sk_rd;
            case ({ret_valid, pop})
                2'b10:   sk_cnt <= sk_cnt + 2'd1;
                2'b01:   sk_cnt <= sk_cnt - 2'd1;
                default: sk_cnt <= sk_cnt;
            endcase
        end
    end

    assign rvalid = (sk_cnt != 2'd0);
    assign rdata  = rvalid ? sk_data[sk_rd] : '0;
    assign rlast  = rvalid && sk_last[sk_rd];
`else
    assign can_issue = 1'b1;
    assign rvalid    = ret_valid;
    assign rlast     = ret_last;
    assign rdata     = ret_valid ? mem_rdata : '0;
`endif

endmodule

// File: tb/tb_fmap_rd_resp.sv
// Self-checking bench for fmap_rd_resp: a request-level schedule model predicts every beat,
// the arready seen by each pulse and ovf_err; directed scenarios plus a randomized run.
module tb_fmap_rd_resp;

    localparam int AW        = 32;
    localparam int DW        = 16;
    localparam int MEM_AW    = 16;
    localparam int MAX_BLOG2 = 5;
    localparam int QDEPTH    = 2;
`ifdef FMAP_RD_RREADY_EN
    localparam int LAT_EXTRA = 1;
`else
    localparam int LAT_EXTRA = 0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [AW-1:0]     araddr = '0;
    logic              arvalid = 1'b0;
    logic [3:0]        arburst = '0;
    logic              arready;
    logic              mem_en;
    logic [MEM_AW-1:0] mem_addr;
    logic [DW-1:0]     mem_rdata = '0;
    logic [DW-1:0]     rdata;
    logic              rvalid, rlast;
    logic              rready = 1'b1;
    logic              ovf_err;

    logic [DW-1:0] mem [0:(1<<MEM_AW)-1];

    int n_cmp = 0;
    int n_bad = 0;

    fmap_rd_resp #(.AW(AW), .DW(DW), .MEM_AW(MEM_AW), .MAX_BLOG2(MAX_BLOG2), .QDEPTH(QDEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .araddr(araddr), .arvalid(arvalid), .arburst(arburst), .arready(arready),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .rdata(rdata), .rvalid(rvalid), .rlast(rlast),
`ifdef FMAP_RD_RREADY_EN
        .rready(rready),
`endif
        .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

    // Scenario stimulus, model expectations and observations
    int                pul_t[$];
    logic [AW-1:0]     pul_a[$];
    logic [3:0]        pul_b[$];
    int                exp_cyc[$], obs_cyc[$];
    logic [DW-1:0]     exp_dat[$], obs_dat[$];
    bit                exp_last[$], obs_last[$];
    logic [MEM_AW-1:0] exp_maddr[$], obs_maddr[$];
    bit                exp_rdy[$], obs_rdy[$];
    bit                exp_ovf;
    int                hold_err, stray_last;
    int                rr_lo_start = -1;
    int                rr_lo_len = 0;

    task automatic clear_scenario();
        pul_t.delete(); pul_a.delete(); pul_b.delete();
        exp_cyc.delete(); exp_dat.delete(); exp_last.delete(); exp_maddr.delete(); exp_rdy.delete();
        obs_cyc.delete(); obs_dat.delete(); obs_last.delete(); obs_maddr.delete(); obs_rdy.delete();
        rr_lo_start = -1;
        rr_lo_len = 0;
    endtask

    task automatic add_pulse(input int t, input logic [AW-1:0] a, input logic [3:0] b);
        pul_t.push_back(t); pul_a.push_back(a); pul_b.push_back(b);
    endtask

    // Request-level schedule: bursts issue one beat per cycle in arrival order. A burst
    // waiting behind a running multi-beat burst leaves the queue at that burst's last
    // issue; otherwise it leaves the queue when its own first beat issues.
    task automatic build_model();
        int acc_t[$], acc_d[$];
        int busy_l = -1;
        bit prev_in_burst = 0;
        exp_ovf = 0;
        foreach (pul_t[i]) begin
            int t, cnt, n, s, d;
            bit dq, rdy, reload;
            t = pul_t[i]; cnt = 0; dq = 0;
            foreach (acc_t[j]) begin
                if (acc_t[j] < t && acc_d[j] >= t) cnt++;
                if (acc_d[j] == t) dq = 1;
            end
            rdy = (cnt < QDEPTH) || dq;
            exp_rdy.push_back(rdy);
            if (int'(pul_b[i]) > MAX_BLOG2) exp_ovf = 1;
            if (!rdy) begin
                exp_ovf = 1;
                continue;
            end
            n = 1 << ((int'(pul_b[i]) > MAX_BLOG2) ? MAX_BLOG2 : int'(pul_b[i]));
            reload = prev_in_burst && (t < busy_l);
            s = reload ? busy_l + 1 : ((t + 1 > busy_l + 1) ? t + 1 : busy_l + 1);
            d = reload ? busy_l : s;
            acc_t.push_back(t);
            acc_d.push_back(d);
            for (int k = 0; k < n; k++) begin
                logic [AW-1:0] a;
                a = pul_a[i] + AW'(k);
                exp_maddr.push_back(a[MEM_AW-1:0]);
                exp_dat.push_back(mem[a[MEM_AW-1:0]]);
                exp_cyc.push_back(s + k + 1 + LAT_EXTRA);
                exp_last.push_back(k == n - 1);
            end
            busy_l = s + n - 1;
            prev_in_burst = (n > 1) || reload;
        end
    endtask

    task automatic run_scenario();
        int pi = 0;
        int ncyc = 0;
        bit prev_stall = 0;
        logic [DW-1:0] prev_d = '0;
        logic prev_l = 1'b0;
        hold_err = 0;
        stray_last = 0;
        if (pul_t.size() > 0) ncyc = pul_t[$];
        if (exp_cyc.size() > 0 && exp_cyc[$] > ncyc) ncyc = exp_cyc[$];
        ncyc = ncyc + 6 + rr_lo_len;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            arvalid = 1'b0;
            if (pi < pul_t.size() && pul_t[pi] == c) begin
                arvalid = 1'b1;
                araddr  = pul_a[pi];
                arburst = pul_b[pi];
                pi++;
            end
            rready = !(c >= rr_lo_start && c < rr_lo_start + rr_lo_len);
            @(negedge clk);
            if (arvalid) obs_rdy.push_back(arready);
            if (mem_en) obs_maddr.push_back(mem_addr);
            if (rlast && !rvalid) stray_last++;
            if (prev_stall && (!rvalid || rdata !== prev_d || rlast !== prev_l)) hold_err++;
            if (rvalid && rready) begin
                obs_cyc.push_back(c);
                obs_dat.push_back(rdata);
                obs_last.push_back(rlast);
            end
            prev_stall = rvalid && !rready;
            prev_d = rdata;
            prev_l = rlast;
        end
        arvalid = 1'b0;
        rready = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        arvalid = 1'b0;
        rready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (arready !== 1'b1) begin n_bad++; $display("FAIL reset arready: got %b want 1", arready); end
        n_cmp++; if (rvalid !== 1'b0)  begin n_bad++; $display("FAIL reset rvalid: got %b want 0", rvalid); end
        n_cmp++; if (rlast !== 1'b0)   begin n_bad++; $display("FAIL reset rlast: got %b want 0", rlast); end
        n_cmp++; if (mem_en !== 1'b0)  begin n_bad++; $display("FAIL reset mem_en: got %b want 0", mem_en); end
        n_cmp++; if (ovf_err !== 1'b0) begin n_bad++; $display("FAIL reset ovf_err: got %b want 0", ovf_err); end
        n_cmp++; if (rdata !== '0)     begin n_bad++; $display("FAIL reset rdata: got %h want 0", rdata); end
        do_reset();
    endtask

    task automatic test_single_burst();
        do_reset(); clear_scenario();
        add_pulse(0, 32'h100, 4'd5);
        build_model(); run_scenario();
        n_cmp++; if (obs_dat.size() != exp_dat.size()) begin n_bad++; $display("FAIL single count: got %0d want %0d", obs_dat.size(), exp_dat.size()); end
        foreach (exp_dat[i]) if (i < obs_dat.size()) begin
            n_cmp++;
            if ({obs_cyc[i], obs_dat[i], obs_last[i]} !== {exp_cyc[i], exp_dat[i], exp_last[i]}) begin
                n_bad++; $display("FAIL single beat %0d: got cyc %0d data %h last %b want cyc %0d data %h last %b", i, obs_cyc[i], obs_dat[i], obs_last[i], exp_cyc[i], exp_dat[i], exp_last[i]);
            end
        end
        n_cmp++; if (ovf_err !== 1'b0 || stray_last != 0) begin n_bad++; $display("FAIL single ovf/stray: got %b/%0d want 0/0", ovf_err, stray_last); end
    endtask

    task automatic test_back_to_back();
        do_reset(); clear_scenario();
        add_pulse(0, 32'h0, 4'd5);
        add_pulse(3, 32'h20, 4'd5);
        build_model(); run_scenario();
        n_cmp++; if (obs_dat.size() != exp_dat.size()) begin n_bad++; $display("FAIL b2b count: got %0d want %0d", obs_dat.size(), exp_dat.size()); end
        foreach (exp_dat[i]) if (i < obs_dat.size()) begin
            n_cmp++;
            if ({obs_cyc[i], obs_dat[i], obs_last[i]} !== {exp_cyc[i], exp_dat[i], exp_last[i]}) begin
                n_bad++; $display("FAIL b2b beat %0d: got cyc %0d data %h last %b want cyc %0d data %h last %b", i, obs_cyc[i], obs_dat[i], obs_last[i], exp_cyc[i], exp_dat[i], exp_last[i]);
            end
        end
        n_cmp++; if (ovf_err !== 1'b0) begin n_bad++; $display("FAIL b2b ovf_err: got %b want 0", ovf_err); end
    endtask

    task automatic test_overflow();
        do_reset(); clear_scenario();
        for (int i = 0; i < 4; i++) add_pulse(i, AW'(i * 64), 4'd5);
        build_model(); run_scenario();
        foreach (exp_rdy[i]) begin
            n_cmp++;
            if (i >= obs_rdy.size() || obs_rdy[i] !== exp_rdy[i]) begin n_bad++; $display("FAIL ovf arready pulse %0d: got %b want %b", i, (i < obs_rdy.size()) ? obs_rdy[i] : 1'bx, exp_rdy[i]); end
        end
        n_cmp++; if (obs_dat.size() != exp_dat.size()) begin n_bad++; $display("FAIL ovf count: got %0d want %0d", obs_dat.size(), exp_dat.size()); end
        foreach (exp_dat[i]) if (i < obs_dat.size()) begin
            n_cmp++;
            if ({obs_cyc[i], obs_dat[i], obs_last[i]} !== {exp_cyc[i], exp_dat[i], exp_last[i]}) begin
                n_bad++; $display("FAIL ovf beat %0d: got cyc %0d data %h want cyc %0d data %h", i, obs_cyc[i], obs_dat[i], exp_cyc[i], exp_dat[i]);
            end
        end
        n_cmp++; if (ovf_err !== exp_ovf) begin n_bad++; $display("FAIL ovf ovf_err: got %b want %b", ovf_err, exp_ovf); end
    endtask

    task automatic test_full_dequeue();
        do_reset(); clear_scenario();
        add_pulse(0, 32'h400, 4'd5);
        add_pulse(1, 32'h500, 4'd5);
        add_pulse(2, 32'h600, 4'd5);
        add_pulse(32, 32'h700, 4'd1);
        build_model(); run_scenario();
        foreach (exp_rdy[i]) begin
            n_cmp++;
            if (i >= obs_rdy.size() || obs_rdy[i] !== exp_rdy[i]) begin n_bad++; $display("FAIL fulldeq arready pulse %0d: got %b want %b", i, (i < obs_rdy.size()) ? obs_rdy[i] : 1'bx, exp_rdy[i]); end
        end
        n_cmp++; if (obs_dat.size() != exp_dat.size()) begin n_bad++; $display("FAIL fulldeq count: got %0d want %0d", obs_dat.size(), exp_dat.size()); end
        n_cmp++; if (ovf_err !== 1'b0) begin n_bad++; $display("FAIL fulldeq ovf_err: got %b want 0", ovf_err); end
    endtask

    task automatic test_clamp_wrap();
        do_reset(); clear_scenario();
        add_pulse(0, 32'h0000FFFE, 4'd7);
        build_model(); run_scenario();
        n_cmp++; if (obs_maddr.size() != exp_maddr.size()) begin n_bad++; $display("FAIL wrap mem_en count: got %0d want %0d", obs_maddr.size(), exp_maddr.size()); end
        foreach (exp_maddr[i]) if (i < obs_maddr.size()) begin
            n_cmp++;
            if (obs_maddr[i] !== exp_maddr[i]) begin n_bad++; $display("FAIL wrap mem_addr %0d: got %h want %h", i, obs_maddr[i], exp_maddr[i]); end
        end
        n_cmp++; if (obs_dat.size() != exp_dat.size()) begin n_bad++; $display("FAIL wrap count: got %0d want %0d", obs_dat.size(), exp_dat.size()); end
        foreach (exp_dat[i]) if (i < obs_dat.size()) begin
            n_cmp++;
            if ({obs_dat[i], obs_last[i]} !== {exp_dat[i], exp_last[i]}) begin n_bad++; $display("FAIL wrap beat %0d: got %h/%b want %h/%b", i, obs_dat[i], obs_last[i], exp_dat[i], exp_last[i]); end
        end
        n_cmp++; if (ovf_err !== 1'b1) begin n_bad++; $display("FAIL wrap ovf_err: got %b want 1", ovf_err); end
    endtask

    task automatic test_reset_mid_burst();
        int beats = 0;
        do_reset(); clear_scenario();
        for (int c = 0; c <= 12; c++) begin
            @(posedge clk);
            #1;
            arvalid = (c == 0);
            araddr  = 32'h300;
            arburst = 4'd5;
            if (c == 11) rst_n = 1'b0;
            @(negedge clk);
            if (c <= 11 && rvalid) beats++;
            if (c == 12) begin
                n_cmp++; if (rvalid !== 1'b0)  begin n_bad++; $display("FAIL midrst rvalid: got %b want 0", rvalid); end
                n_cmp++; if (rlast !== 1'b0)   begin n_bad++; $display("FAIL midrst rlast: got %b want 0", rlast); end
                n_cmp++; if (arready !== 1'b1) begin n_bad++; $display("FAIL midrst arready: got %b want 1", arready); end
            end
        end
        n_cmp++; if (beats != 10 - LAT_EXTRA) begin n_bad++; $display("FAIL midrst beats before reset: got %0d want %0d", beats, 10 - LAT_EXTRA); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        add_pulse(0, 32'h40, 4'd2);
        build_model(); run_scenario();
        n_cmp++; if (obs_dat.size() != exp_dat.size()) begin n_bad++; $display("FAIL midrst count: got %0d want %0d", obs_dat.size(), exp_dat.size()); end
        foreach (exp_dat[i]) if (i < obs_dat.size()) begin
            n_cmp++;
            if ({obs_cyc[i], obs_dat[i], obs_last[i]} !== {exp_cyc[i], exp_dat[i], exp_last[i]}) begin
                n_bad++; $display("FAIL midrst beat %0d: got cyc %0d data %h last %b want cyc %0d data %h last %b", i, obs_cyc[i], obs_dat[i], obs_last[i], exp_cyc[i], exp_dat[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_random();
        do_reset(); clear_scenario();
        for (int c = 0; c < 200; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                logic [3:0] b;
                b = ($urandom_range(0, 9) == 0) ? 4'(($urandom_range(6, 15))) : 4'($urandom_range(0, 3));
                add_pulse(c, $urandom, b);
            end
        end
        build_model(); run_scenario();
        foreach (exp_rdy[i]) begin
            n_cmp++;
            if (i >= obs_rdy.size() || obs_rdy[i] !== exp_rdy[i]) begin n_bad++; $display("FAIL rand arready pulse %0d: got %b want %b", i, (i < obs_rdy.size()) ? obs_rdy[i] : 1'bx, exp_rdy[i]); end
        end
        n_cmp++; if (obs_dat.size() != exp_dat.size()) begin n_bad++; $display("FAIL rand count: got %0d want %0d", obs_dat.size(), exp_dat.size()); end
        foreach (exp_dat[i]) if (i < obs_dat.size()) begin
            n_cmp++;
            if ({obs_cyc[i], obs_dat[i], obs_last[i]} !== {exp_cyc[i], exp_dat[i], exp_last[i]}) begin
                n_bad++; $display("FAIL rand beat %0d: got cyc %0d data %h last %b want cyc %0d data %h last %b", i, obs_cyc[i], obs_dat[i], obs_last[i], exp_cyc[i], exp_dat[i], exp_last[i]);
            end
        end
        n_cmp++; if (ovf_err !== exp_ovf || stray_last != 0) begin n_bad++; $display("FAIL rand ovf/stray: got %b/%0d want %b/0", ovf_err, stray_last, exp_ovf); end
    endtask

`ifdef FMAP_RD_RREADY_EN
    task automatic test_rready();
        int lasts = 0;
        do_reset(); clear_scenario();
        add_pulse(0, 32'h200, 4'd5);
        build_model();
        rr_lo_start = 6;
        rr_lo_len = 5;
        run_scenario();
        n_cmp++; if (obs_dat.size() != exp_dat.size()) begin n_bad++; $display("FAIL rready count: got %0d want %0d", obs_dat.size(), exp_dat.size()); end
        foreach (exp_dat[i]) if (i < obs_dat.size()) begin
            n_cmp++;
            if ({obs_dat[i], obs_last[i]} !== {exp_dat[i], exp_last[i]}) begin n_bad++; $display("FAIL rready beat %0d: got %h/%b want %h/%b", i, obs_dat[i], obs_last[i], exp_dat[i], exp_last[i]); end
        end
        foreach (obs_last[i]) if (obs_last[i]) lasts++;
        n_cmp++; if (lasts != 1) begin n_bad++; $display("FAIL rready rlast count: got %0d want 1", lasts); end
        n_cmp++; if (hold_err != 0 || stray_last != 0) begin n_bad++; $display("FAIL rready hold/stray: got %0d/%0d want 0/0", hold_err, stray_last); end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << MEM_AW); i++) mem[i] = DW'(i);
        test_reset();
        test_single_burst();
        test_back_to_back();
        test_overflow();
        test_full_dequeue();
        test_clamp_wrap();
        test_reset_mid_burst();
        test_random();
`ifdef FMAP_RD_RREADY_EN
        test_rready();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fmap_rd_resp.md
# fmap_rd_resp

Read-channel responder serving the input buffer's burst address generator. Accepts single-cycle read address pulses (`araddr`/`arvalid`/`arburst`), queues them, and fetches each burst from a single-port on-chip feature-map SRAM with 1-cycle read latency. It returns one element per beat on `rdata`/`rvalid` and marks the final beat with `rlast`, closing the loop that drives the generator's row, block and map counters.

## Interface
- `AW`, 32, address width of `araddr`.
- `DW`, 16, element width, one element per beat.
- `MEM_AW`, 16, SRAM word-address width; `mem_addr` = `araddr` low `MEM_AW` bits.
- `MAX_BLOG2`, 5, largest accepted `arburst` value (32 beats).
- `QDEPTH`, 2, request queue depth.
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `araddr`  in  AW  element start address of the burst.
- `arvalid`  in  1  single-cycle request pulse.
- `arburst`  in  4  burst length as log2 of the beat count.
- `arready`  out  1  queue can accept this cycle; informational, because the initiator does not wait on it.
- `mem_en`  out  1  SRAM read enable.
- `mem_addr`  out  MEM_AW  SRAM word address.
- `mem_rdata`  in  DW  SRAM data, valid the cycle after `mem_en`.
- `rdata`  out  DW  beat data.
- `rvalid`  out  1  beat valid.
- `rlast`  out  1  final beat of the burst; only asserted together with `rvalid`.
- `rready`  in  1  consumer ready; present only with `FMAP_RD_RREADY_EN`.
- `ovf_err`  out  1  sticky: a request was dropped, or `arburst` was clamped.

## Operation
- Request queue: FIFO of {araddr, clamped arburst}, QDEPTH entries.
  - `arready` = not full, or a dequeue happens this cycle.
  - `arvalid` with `arready` high: enqueue.
  - `arvalid` with `arready` low: drop the request and set `ovf_err`.
  - `arburst` > MAX_BLOG2: clamp to MAX_BLOG2 and set `ovf_err`.
- Issue FSM, states IDLE and BURST.
  - IDLE, queue not empty: dequeue; load addr counter = araddr and beat counter = (1<<blog2) − 1; go to BURST.
  - BURST, each issue cycle: `mem_en`=1, `mem_addr`=addr[MEM_AW-1:0], addr+1, beat−1. The address wraps modulo 2^MEM_AW.
  - BURST, last beat issued: if the queue is not empty, dequeue and reload in the same cycle (no bubble). Otherwise return to IDLE.
- Return pipe: `mem_en` delayed 1 cycle produces `rvalid`. `rlast` is the delayed last-beat flag. `rdata` = `mem_rdata` (registered in the skid stage with the macro).
- Reset values: `arready`=1, all other outputs 0, queue empty, FSM in IDLE. Asserting reset mid-burst discards queued and in-flight beats; no `rlast` is emitted for the aborted burst.

## Timing
- `arvalid` at cycle T with the block idle: `mem_en` at T+1 and first `rvalid` at T+2.
- A burst of N beats has its last beat (`rvalid` and `rlast`) at T+1+N.
- Back-to-back queued bursts produce contiguous beats with no idle cycle between `rlast` and the next first beat.
- Simultaneous `arvalid` and dequeue while the queue is full: the request is accepted and `ovf_err` is not set.
- `ovf_err` clears only on reset.

## Configuration
- `FMAP_RD_RREADY_EN` defined:
  - The `rready` port exists and a 2-entry skid buffer sits after the SRAM.
  - `mem_en` is issued only when the skid buffer will have a free slot.
  - While `rvalid`=1 and `rready`=0, `rdata` and `rlast` hold stable.
  - First-beat latency becomes T+3.
- Undefined: no `rready` port; beats stream unconditionally every cycle, with the latency given under Timing.

## Test plan
- Single burst: SRAM preloaded with mem[i]=i. `araddr`=0x100, `arburst`=5 at T -> 32 beats on T+2..T+33 with `rdata` 0x100..0x11F, `rlast` only at T+33.
- Back-to-back: pulses at T (addr 0x0, `arburst` 5) and T+3 (addr 0x20, `arburst` 5) -> 64 contiguous beats with `rdata` 0x00..0x3F, `rlast` at T+33 and T+65, `ovf_err`=0.
- Overflow: four pulses in 4 consecutive cycles, `arburst`=5, block idle -> 3 bursts returned, the fourth dropped, `ovf_err`=1.
- Clamp and wrap: `araddr`=0xFFFE with `MEM_AW`=16 and `arburst`=7 -> 32 beats with `mem_addr` 0xFFFE, 0xFFFF, 0x0000…, and `ovf_err`=1.
- Reset mid-burst: `rst_n` low at beat 10 of a 32-beat burst -> the next cycle has `rvalid`=0, `rlast`=0 and `arready`=1. A new pulse after reset gets a normal T+2 response.
- With `FMAP_RD_RREADY_EN`: `rready` low for 5 cycles at beat 4 -> `rdata` held, no beat lost or duplicated, and 32 beats total with a single `rlast`.
